// File: rtl/wordreg_file.sv
// wordreg_file: DEPTH x WIDTH register file with one write port, two
// combinational read ports, a tristate bus driver and a per-register busy
// scoreboard used by the sequencer to detect RAW/WAW hazards.
// Optional build macro: WORDREG_FILE_BYPASS_EN (write-to-read forwarding).
`timescale 1ns/1ps
module wordreg_file #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    inout  wire  [WIDTH-1:0]  bus,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic              i_w,
    input  logic              i_bus_w,
    input  logic              i_s,
    input  logic [ADDR_W-1:0] i_saddr,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [WIDTH-1:0]  o_rdata_a,
    output logic [WIDTH-1:0]  o_rdata_b,
    input  logic              i_claim,
    input  logic [ADDR_W-1:0] i_claim_addr,
    output logic              o_busy_a,
    output logic              o_busy_b,
    output logic              o_stall,
    output logic [ADDR_W:0]   o_busy_count
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  busy_count_q, busy_count_d;
    logic [WIDTH-1:0] wsrc;
    logic             claim_ok;

    // Write source: the bus when i_bus_w, so a bus move (i_s with i_bus_w)
    // copies reg[i_saddr] into reg[i_waddr] in a single cycle.
    assign wsrc = i_bus_w ? bus : i_wdata;

    // Bus driver is purely a function of i_s; released to Z otherwise.
    assign bus = i_s ? regs_q[i_saddr] : {WIDTH{1'bz}};

    // A claim is rejected only if the target is busy and no write retires it this edge.
    assign o_stall  = i_claim & busy_q[i_claim_addr] & ~(i_w & (i_waddr == i_claim_addr));
    assign claim_ok = i_claim & ~o_stall;

    // Next scoreboard state: write clears, accepted claim sets (claim wins on same address).
    always_comb begin
        busy_d = busy_q;
        if (i_w)
            busy_d[i_waddr] = 1'b0;
        if (claim_ok)
            busy_d[i_claim_addr] = 1'b1;
    end

    // Population count of the next busy vector so the count tracks the bits exactly.
    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < DEPTH; i++)
            busy_count_d = busy_count_d + (ADDR_W+1)'(busy_d[i]);
    end

    // Register array and scoreboard state.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            if (i_w)
                regs_q[i_waddr] <= wsrc;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign o_busy_count = busy_count_q;

`ifdef WORDREG_FILE_BYPASS_EN
    logic hit_a, hit_b;
    assign hit_a = i_w & (i_waddr == i_raddr_a);
    assign hit_b = i_w & (i_waddr == i_raddr_b);

    // Forward the in-flight write; a forwarded register is busy only if re-claimed now.
    always_comb begin
        o_rdata_a = hit_a ? wsrc : regs_q[i_raddr_a];
        o_rdata_b = hit_b ? wsrc : regs_q[i_raddr_b];
        o_busy_a  = hit_a ? (claim_ok & (i_claim_addr == i_raddr_a)) : busy_q[i_raddr_a];
        o_busy_b  = hit_b ? (claim_ok & (i_claim_addr == i_raddr_b)) : busy_q[i_raddr_b];
    end
`else
    // Plain reads of stored state; writes become visible after the edge.
    always_comb begin
        o_rdata_a = regs_q[i_raddr_a];
        o_rdata_b = regs_q[i_raddr_b];
        o_busy_a  = busy_q[i_raddr_a];
        o_busy_b  = busy_q[i_raddr_b];
    end
`endif

endmodule

// File: tb/tb_wordreg_file.sv
// Self-checking bench for wordreg_file: directed table, hand sequences for
// bus/move/bypass/async reset, then randomized traffic against an array model.
`timescale 1ns/1ps
module tb_wordreg_file;

    logic        clk = 1'b0, rst = 1'b1;
    wire  [15:0] bus;
    logic [15:0] wdata = '0;
    logic [2:0]  waddr = '0, saddr = '0, ra = '0, rb = '0, caddr = '0;
    logic        w = 0, bus_w = 0, s = 0, claim = 0;
    logic [15:0] rda, rdb;
    logic        busy_a, busy_b, stall;
    logic [3:0]  cnt;
    logic        drv_en = 0;
    logic [15:0] drv = '0;

    int checks = 0, failures = 0;

`ifdef WORDREG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    assign bus = drv_en ? drv : 16'bz;
    always #5 clk = ~clk;

    wordreg_file dut (
        .i_clock(clk), .i_reset(rst), .bus(bus), .i_wdata(wdata), .i_waddr(waddr),
        .i_w(w), .i_bus_w(bus_w), .i_s(s), .i_saddr(saddr), .i_raddr_a(ra),
        .i_raddr_b(rb), .o_rdata_a(rda), .o_rdata_b(rdb), .i_claim(claim),
        .i_claim_addr(caddr), .o_busy_a(busy_a), .o_busy_b(busy_b), .o_stall(stall),
        .o_busy_count(cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        w = 0; bus_w = 0; s = 0; claim = 0; drv_en = 0;
        wdata = '0; waddr = '0; saddr = '0; caddr = '0;
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic        claim;
        logic [2:0]  caddr;
        logic [2:0]  ra;
        logic [15:0] exp_rd;
        logic        exp_busy;
        logic        exp_stall;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t tbl [11];

    // Behavioural model
    logic [15:0] m_reg  [8];
    bit          m_busy [8];

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    initial begin
        // expectations sampled before the edge; count reflects previous edges
        tbl[0]  = '{1, 3, 16'hBEEF, 0, 0, 0, 16'h0000, 0, 0, 0};
        tbl[1]  = '{0, 0, 16'h0000, 1, 2, 3, 16'hBEEF, 0, 0, 0};
        tbl[2]  = '{0, 0, 16'h0000, 1, 2, 2, 16'h0000, 1, 1, 1};
        tbl[3]  = '{1, 2, 16'h0042, 0, 0, 3, 16'hBEEF, 0, 0, 1};
        tbl[4]  = '{0, 0, 16'h0000, 1, 4, 2, 16'h0042, 0, 0, 0};
        tbl[5]  = '{1, 4, 16'h1234, 1, 4, 2, 16'h0042, 0, 0, 1};
        tbl[6]  = '{0, 0, 16'h0000, 0, 0, 4, 16'h1234, 1, 0, 1};
        tbl[7]  = '{1, 7, 16'hFFFF, 1, 7, 4, 16'h1234, 1, 0, 1};
        tbl[8]  = '{0, 0, 16'h0000, 1, 4, 7, 16'hFFFF, 1, 1, 2};
        tbl[9]  = '{1, 4, 16'h0001, 1, 4, 7, 16'hFFFF, 1, 0, 2};
        tbl[10] = '{0, 0, 16'h0000, 0, 0, 4, 16'h0001, 1, 0, 2};

        // ---- reset state ----
        idle();
        #12 @(negedge clk) rst = 0;
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i); rb = 3'(7 - i);
            #1;
            chk("reset_rda", {16'h0, rda}, 0);
            chk("reset_rdb", {16'h0, rdb}, 0);
            chk("reset_busy", {30'h0, busy_a, busy_b}, 0);
        end
        chk("reset_cnt", {28'h0, cnt}, 0);
        drv_en = 1; drv = 16'h3C3C; #1;
        chk("reset_bus_released", {16'h0, bus}, 32'h3C3C);
        drv_en = 0;

        // ---- directed table ----
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            idle();
            w = tbl[k].w; waddr = tbl[k].waddr; wdata = tbl[k].wdata;
            claim = tbl[k].claim; caddr = tbl[k].caddr;
            ra = tbl[k].ra; rb = tbl[k].ra;
            #1;
            chk($sformatf("tbl%0d_rda", k), {16'h0, rda}, {16'h0, tbl[k].exp_rd});
            chk($sformatf("tbl%0d_rdb", k), {16'h0, rdb}, {16'h0, tbl[k].exp_rd});
            chk($sformatf("tbl%0d_busy", k), {31'h0, busy_a}, {31'h0, tbl[k].exp_busy});
            chk($sformatf("tbl%0d_stall", k), {31'h0, stall}, {31'h0, tbl[k].exp_stall});
            chk($sformatf("tbl%0d_cnt", k), {28'h0, cnt}, {28'h0, tbl[k].exp_cnt});
        end
        // state now: r2=0042 r3=BEEF r4=0001 r7=FFFF, busy r4,r7

        // ---- bus drive and release ----
        @(negedge clk); idle(); s = 1; saddr = 3; #1;
        chk("bus_drive_r3", {16'h0, bus}, 32'hBEEF);
        @(negedge clk); idle(); drv_en = 1; drv = 16'h5A5A; #1;
        chk("bus_released", {16'h0, bus}, 32'h5A5A);

        // ---- bus move r3 -> r5 ----
        @(negedge clk); idle(); s = 1; saddr = 3; bus_w = 1; w = 1; waddr = 5;
        @(negedge clk); idle(); ra = 5; #1;
        chk("bus_move_r5", {16'h0, rda}, 32'hBEEF);
        // move onto itself keeps value
        @(negedge clk); idle(); s = 1; saddr = 3; bus_w = 1; w = 1; waddr = 3;
        @(negedge clk); idle(); ra = 3; #1;
        chk("bus_move_self", {16'h0, rda}, 32'hBEEF);
        // external bus write
        @(negedge clk); idle(); drv_en = 1; drv = 16'h7E57; bus_w = 1; w = 1; waddr = 0;
        @(negedge clk); idle(); ra = 0; #1;
        chk("bus_write_r0", {16'h0, rda}, 32'h7E57);

        // ---- forwarding / write latency ----
        @(negedge clk); idle(); w = 1; waddr = 6; wdata = 16'hA5A5; rb = 6; #1;
        chk("bypass_same_cycle", {16'h0, rdb}, BYP ? 32'hA5A5 : 32'h0);
        @(negedge clk); idle(); rb = 6; #1;
        chk("write_next_cycle", {16'h0, rdb}, 32'hA5A5);
        // forwarded busy: writing busy r7 without re-claim
        @(negedge clk); idle(); w = 1; waddr = 7; wdata = 16'h0707; ra = 7; #1;
        chk("bypass_busy_a", {31'h0, busy_a}, BYP ? 0 : 1);

        // ---- async reset mid-write/mid-claim ----
        @(negedge clk); idle(); w = 1; waddr = 3; wdata = 16'h1111; claim = 1; caddr = 2;
        ra = 6; rb = 5;
        #2 rst = 1; #1;
        chk("async_rst_rda", {16'h0, rda}, 0);
        chk("async_rst_rdb", {16'h0, rdb}, 0);
        chk("async_rst_cnt", {28'h0, cnt}, 0);
        chk("async_rst_stall", {31'h0, stall}, 0);
        @(posedge clk); #1;
        chk("rst_hold_rda", {16'h0, rda}, 0);
        @(negedge clk); idle(); rst = 0; ra = 3; rb = 2; #1;
        chk("post_rst_r3", {16'h0, rda}, 0);
        chk("post_rst_busy", {30'h0, busy_a, busy_b}, 0);

        // ---- randomized against model ----
        for (int i = 0; i < 8; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
        for (int n = 0; n < 400; n++) begin
            logic [15:0] busval, src, e_a, e_b;
            logic        e_stall, e_ba, e_bb, hit_a, hit_b, acc;
            @(negedge clk);
            idle();
            s      = ($urandom_range(0, 2) == 0);
            saddr  = 3'($urandom);
            drv_en = !s; drv = 16'($urandom);
            w      = $urandom_range(0, 1);
            waddr  = 3'($urandom);
            wdata  = 16'($urandom);
            bus_w  = ($urandom_range(0, 3) == 0);
            claim  = ($urandom_range(0, 1) == 1);
            caddr  = 3'($urandom);
            ra     = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom);
            rb     = ($urandom_range(0, 3) == 0) ? ra : 3'($urandom);
            busval = s ? m_reg[saddr] : drv;
            src    = bus_w ? busval : wdata;
            e_stall = claim && m_busy[caddr] && !(w && waddr == caddr);
            acc    = claim && !e_stall;
            hit_a  = BYP && w && waddr == ra;
            hit_b  = BYP && w && waddr == rb;
            e_a    = hit_a ? src : m_reg[ra];
            e_b    = hit_b ? src : m_reg[rb];
            e_ba   = hit_a ? (acc && caddr == ra) : m_busy[ra];
            e_bb   = hit_b ? (acc && caddr == rb) : m_busy[rb];
            #1;
            chk("rnd_rda", {16'h0, rda}, {16'h0, e_a});
            chk("rnd_rdb", {16'h0, rdb}, {16'h0, e_b});
            chk("rnd_busy", {30'h0, busy_a, busy_b}, {30'h0, e_ba, e_bb});
            chk("rnd_stall", {31'h0, stall}, {31'h0, e_stall});
            chk("rnd_cnt", {28'h0, cnt}, 32'(m_count()));
            if (s) chk("rnd_bus", {16'h0, bus}, {16'h0, m_reg[saddr]});
            @(posedge clk);
            if (w) begin m_reg[waddr] = src; m_busy[waddr] = 0; end
            if (acc) m_busy[caddr] = 1;
        end
        @(negedge clk); idle(); #1;
        chk("final_cnt", {28'h0, cnt}, 32'(m_count()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
